// File: rtl/tcdm_rr_arbiter.sv
// rtl/tcdm_rr_arbiter.sv - round-robin arbiter sharing one TCDM port with an in-order response tag fifo
module tcdm_rr_arbiter #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned IdxWidth       = $clog2(NumIn)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  // upstream requests, requester i at slice i
  input  logic [NumIn-1:0]                    in_q_valid_i,
  output logic [NumIn-1:0]                    in_q_ready_o,
  input  logic [NumIn*AddrWidth-1:0]          in_q_addr_i,
  input  logic [NumIn-1:0]                    in_q_write_i,
  input  logic [NumIn*4-1:0]                  in_q_amo_i,
  input  logic [NumIn*DataWidth-1:0]          in_q_data_i,
  input  logic [NumIn*(DataWidth/8)-1:0]      in_q_strb_i,
  // upstream responses
  output logic [NumIn-1:0]                    in_p_valid_o,
  output logic [NumIn*DataWidth-1:0]          in_p_data_o,
  // downstream request
  output logic                                out_q_valid_o,
  input  logic                                out_q_ready_i,
  output logic [AddrWidth-1:0]                out_q_addr_o,
  output logic                                out_q_write_o,
  output logic [3:0]                          out_q_amo_o,
  output logic [DataWidth-1:0]                out_q_data_o,
  output logic [DataWidth/8-1:0]              out_q_strb_o,
  // downstream response, no backpressure
  input  logic                                out_p_valid_i,
  input  logic [DataWidth-1:0]                out_p_data_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned PtrWidth  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

  // arbitration state
  logic [IdxWidth-1:0] prio_q, prio_d;
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;

  // tag fifo state
  logic [IdxWidth-1:0] tags_q [MaxOutstanding];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic [IdxWidth-1:0] rr_idx;
  logic                rr_found;
  logic [IdxWidth-1:0] gnt_idx;
  logic [IdxWidth-1:0] head_idx;
  logic                any_valid;
  logic                fifo_full;
  logic                fifo_empty;
  logic                handshake;
  logic                stall;
  logic                push;
  logic                pop;

  // Advance a fifo pointer, wrapping at the fifo depth.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrWidth'(MaxOutstanding - 1)) begin
      return '0;
    end
    return ptr + PtrWidth'(1);
  endfunction

  assign any_valid  = |in_q_valid_i;
  assign fifo_full  = (cnt_q == CntWidth'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign head_idx   = tags_q[rd_ptr_q];

  // Round-robin search starting at prio_q, wrapping modulo NumIn.
  always_comb begin
    int                  cand;
    logic [IdxWidth-1:0] cand_idx;
    rr_idx   = prio_q;
    rr_found = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < int'(NumIn); k++) begin
      cand = int'(prio_q) + k;
      if (cand >= int'(NumIn)) begin
        cand = cand - int'(NumIn);
      end
      cand_idx = IdxWidth'(cand);
      if (!rr_found && in_q_valid_i[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // A stalled grant stays pinned to the locked requester.
  assign gnt_idx = lock_q ? lock_idx_q : rr_idx;

  // A pop does not free a slot for a push in the same cycle, so out_p_valid_i
  // never reaches out_q_valid_o combinationally.
  assign out_q_valid_o = !rst_i && any_valid && !fifo_full;
  assign handshake     = out_q_valid_o && out_q_ready_i;
  assign stall         = out_q_valid_o && !out_q_ready_i;
  assign push          = handshake;
  assign pop           = !rst_i && out_p_valid_i && !fifo_empty;

  // Request fields of the granted requester.
  assign out_q_addr_o  = in_q_addr_i[gnt_idx*AddrWidth +: AddrWidth];
  assign out_q_write_o = in_q_write_i[gnt_idx];
  assign out_q_amo_o   = in_q_amo_i[gnt_idx*4 +: 4];
  assign out_q_data_o  = in_q_data_i[gnt_idx*DataWidth +: DataWidth];
  assign out_q_strb_o  = in_q_strb_i[gnt_idx*StrbWidth +: StrbWidth];

  // Only the granted requester sees ready.
  always_comb begin
    in_q_ready_o = '0;
    if (!rst_i && any_valid && !fifo_full && out_q_ready_i) begin
      in_q_ready_o[gnt_idx] = 1'b1;
    end
  end

  // Route the response to the requester at the fifo head.
  always_comb begin
    in_p_valid_o = '0;
    if (pop) begin
      in_p_valid_o[head_idx] = 1'b1;
    end
  end

  assign in_p_data_o = {NumIn{out_p_data_i}};

  // Next-state for the priority pointer and the lock.
  always_comb begin
    prio_d     = prio_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (handshake) begin
      prio_d = (gnt_idx == IdxWidth'(NumIn - 1)) ? '0 : gnt_idx + IdxWidth'(1);
      lock_d = 1'b0;
    end else if (stall) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
  end

  // Next-state for the fifo pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Register arbitration and fifo control state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Store the granted index; entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tags_q[wr_ptr_q] <= gnt_idx;
    end
  end

  // Flag a response arriving with no outstanding tag.
  always_ff @(posedge clk_i) begin
    if (!rst_i && out_p_valid_i) begin
      assert (!fifo_empty)
        else $error("tcdm_rr_arbiter: response received with empty tag fifo");
    end
  end

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// tb/tb_tcdm_rr_arbiter.sv - directed self-checking bench for tcdm_rr_arbiter
module tb_tcdm_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_q_valid;
  logic [N-1:0]      in_q_ready;
  logic [N*AW-1:0]   in_q_addr;
  logic [N-1:0]      in_q_write;
  logic [N*4-1:0]    in_q_amo;
  logic [N*DW-1:0]   in_q_data;
  logic [N*SW-1:0]   in_q_strb;
  logic [N-1:0]      in_p_valid;
  logic [N*DW-1:0]   in_p_data;
  logic              out_q_valid;
  logic              out_q_ready;
  logic [AW-1:0]     out_q_addr;
  logic              out_q_write;
  logic [3:0]        out_q_amo;
  logic [DW-1:0]     out_q_data;
  logic [SW-1:0]     out_q_strb;
  logic              out_p_valid;
  logic [DW-1:0]     out_p_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tcdm_rr_arbiter #(
    .NumIn(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_q_valid_i(in_q_valid), .in_q_ready_o(in_q_ready),
    .in_q_addr_i(in_q_addr), .in_q_write_i(in_q_write),
    .in_q_amo_i(in_q_amo), .in_q_data_i(in_q_data), .in_q_strb_i(in_q_strb),
    .in_p_valid_o(in_p_valid), .in_p_data_o(in_p_data),
    .out_q_valid_o(out_q_valid), .out_q_ready_i(out_q_ready),
    .out_q_addr_o(out_q_addr), .out_q_write_o(out_q_write),
    .out_q_amo_o(out_q_amo), .out_q_data_o(out_q_data), .out_q_strb_o(out_q_strb),
    .out_p_valid_i(out_p_valid), .out_p_data_i(out_p_data)
  );

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h1000 + AW'(i * 16);
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int i);
    return 64'hD000 + DW'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    int prev;
    rst         = 1'b1;
    in_q_valid  = '0;
    out_q_ready = 1'b0;
    out_p_valid = 1'b0;
    out_p_data  = '0;
    in_q_write  = 4'b0101;
    in_q_amo    = 16'h4321;
    for (int i = 0; i < N; i++) begin
      in_q_addr[i*AW +: AW] = addr_of(i);
      in_q_data[i*DW +: DW] = wdata_of(i);
      in_q_strb[i*SW +: SW] = 8'hF0 | 8'(i);
    end
    tick();

    // reset: outputs forced low even with active stimulus
    in_q_valid = 4'hF; out_q_ready = 1'b1; out_p_valid = 1'b1; out_p_data = 64'hDEAD;
    settle();
    chk("rst_out_q_valid", 64'(out_q_valid), 64'd0);
    chk("rst_in_q_ready", 64'(in_q_ready), 64'd0);
    chk("rst_in_p_valid", 64'(in_p_valid), 64'd0);
    tick();
    rst = 1'b0; in_q_valid = '0; out_q_ready = 1'b0; out_p_valid = 1'b0;
    settle();
    chk("idle_out_q_valid", 64'(out_q_valid), 64'd0);
    tick();

    // fairness plus simultaneous push/pop at count 1 over 10 iterations
    in_q_valid = 4'hF; out_q_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      prev        = (c + 3) % 4;
      out_p_valid = (c > 0);
      out_p_data  = 64'hA0 + 64'(prev);
      settle();
      chk("fair_out_q_valid", 64'(out_q_valid), 64'd1);
      chk("fair_addr", 64'(out_q_addr), 64'(addr_of(c % 4)));
      chk("fair_data", out_q_data, wdata_of(c % 4));
      chk("fair_write", 64'(out_q_write), 64'(in_q_write[c % 4]));
      chk("fair_in_q_ready", 64'(in_q_ready), 64'(4'b0001 << (c % 4)));
      if (c > 0) begin
        chk("fair_in_p_valid", 64'(in_p_valid), 64'(4'b0001 << prev));
        chk("fair_in_p_data", in_p_data[prev*DW +: DW], 64'hA0 + 64'(prev));
      end else begin
        chk("fair_in_p_valid_first", 64'(in_p_valid), 64'd0);
      end
      tick();
    end
    in_q_valid = '0; out_p_valid = 1'b1; out_p_data = 64'hA2;
    settle();
    chk("fair_drain_p_valid", 64'(in_p_valid), 64'b0100);
    chk("fair_drain_q_valid", 64'(out_q_valid), 64'd0);
    tick();
    out_p_valid = 1'b0;

    // lock: requester 2 stalled, requester 0 joins while pointer would favour it
    in_q_valid = 4'b0100; out_q_ready = 1'b0;
    settle();
    chk("lock_out_q_valid", 64'(out_q_valid), 64'd1);
    chk("lock_addr0", 64'(out_q_addr), 64'(addr_of(2)));
    chk("lock_ready0", 64'(in_q_ready), 64'd0);
    tick();
    in_q_valid = 4'b0101;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("lock_addr_held", 64'(out_q_addr), 64'(addr_of(2)));
      chk("lock_ready_held", 64'(in_q_ready), 64'd0);
      tick();
    end
    out_q_ready = 1'b1;
    settle();
    chk("lock_release_ready", 64'(in_q_ready), 64'b0100);
    chk("lock_release_addr", 64'(out_q_addr), 64'(addr_of(2)));
    tick();
    in_q_valid = 4'b0001;
    settle();
    chk("lock_next_ready", 64'(in_q_ready), 64'b0001);
    chk("lock_next_addr", 64'(out_q_addr), 64'(addr_of(0)));
    tick();
    in_q_valid = '0; out_p_valid = 1'b1; out_p_data = 64'hB2;
    settle();
    chk("lock_resp2", 64'(in_p_valid), 64'b0100);
    chk("lock_resp2_data", in_p_data[2*DW +: DW], 64'hB2);
    tick();
    out_p_data = 64'hB0;
    settle();
    chk("lock_resp0", 64'(in_p_valid), 64'b0001);
    tick();
    out_p_valid = 1'b0;

    // full: two handshakes then stall until a response frees a slot
    in_q_valid = 4'b1010; out_q_ready = 1'b1;
    settle();
    chk("full_ready_a", 64'(in_q_ready), 64'b0010);
    tick();
    settle();
    chk("full_ready_b", 64'(in_q_ready), 64'b1000);
    chk("full_addr_b", 64'(out_q_addr), 64'(addr_of(3)));
    tick();
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("full_q_valid", 64'(out_q_valid), 64'd0);
      chk("full_ready", 64'(in_q_ready), 64'd0);
      tick();
    end
    out_p_valid = 1'b1; out_p_data = 64'hC1;
    settle();
    chk("full_resp1", 64'(in_p_valid), 64'b0010);
    chk("full_no_push_on_pop", 64'(out_q_valid), 64'd0);
    tick();
    out_p_valid = 1'b0; in_q_valid = 4'b1000;
    settle();
    chk("full_regrant_valid", 64'(out_q_valid), 64'd1);
    chk("full_regrant_ready", 64'(in_q_ready), 64'b1000);
    tick();
    in_q_valid = '0; out_p_valid = 1'b1; out_p_data = 64'hC3;
    settle();
    chk("full_resp3a", 64'(in_p_valid), 64'b1000);
    tick();
    out_p_data = 64'hC4;
    settle();
    chk("full_resp3b", 64'(in_p_valid), 64'b1000);
    tick();
    out_p_valid = 1'b0;

    // ordering: grant 3 then 1, responses A then B
    in_q_valid = 4'b1000;
    settle();
    chk("ord_ready3", 64'(in_q_ready), 64'b1000);
    tick();
    in_q_valid = 4'b0010;
    settle();
    chk("ord_ready1", 64'(in_q_ready), 64'b0010);
    tick();
    in_q_valid = '0; out_p_valid = 1'b1; out_p_data = 64'hA;
    settle();
    chk("ord_resp_a_valid", 64'(in_p_valid), 64'b1000);
    chk("ord_resp_a_data", in_p_data[3*DW +: DW], 64'hA);
    tick();
    out_p_data = 64'hB;
    settle();
    chk("ord_resp_b_valid", 64'(in_p_valid), 64'b0010);
    chk("ord_resp_b_data", in_p_data[1*DW +: DW], 64'hB);
    tick();
    out_p_valid = 1'b0;

    // reset mid-flight with two outstanding tags
    in_q_valid = 4'b0011;
    settle();
    chk("rmf_ready0", 64'(in_q_ready), 64'b0001);
    tick();
    settle();
    chk("rmf_ready1", 64'(in_q_ready), 64'b0010);
    tick();
    rst = 1'b1; in_q_valid = 4'hF; out_p_valid = 1'b1; out_p_data = 64'hEE;
    settle();
    chk("rmf_rst_q_valid", 64'(out_q_valid), 64'd0);
    chk("rmf_rst_ready", 64'(in_q_ready), 64'd0);
    chk("rmf_rst_p_valid", 64'(in_p_valid), 64'd0);
    tick();
    rst = 1'b0; out_p_valid = 1'b0;
    settle();
    chk("rmf_after_q_valid", 64'(out_q_valid), 64'd1);
    chk("rmf_after_grant0", 64'(in_q_ready), 64'b0001);
    tick();
    settle();
    chk("rmf_after_grant1", 64'(in_q_ready), 64'b0010);
    tick();
    settle();
    chk("rmf_after_full", 64'(out_q_valid), 64'd0);
    tick();
    in_q_valid = '0; out_p_valid = 1'b1; out_p_data = 64'h11;
    settle();
    chk("rmf_resp0", 64'(in_p_valid), 64'b0001);
    tick();
    out_p_data = 64'h22;
    settle();
    chk("rmf_resp1", 64'(in_p_valid), 64'b0010);
    tick();
    out_p_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
